pipe_scoreboard: RTL and testbench
==================================

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of post-issue stages whose register write is pending (legal 1..8).
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid  input  1  decode stage holds an instruction requesting issue.
REQ-007 SHALL have ports issue_rs, issue_rt  input  REG_AW each  source register addresses.
REQ-008 SHALL have ports issue_rs_used, issue_rt_used  input  1 each  source actually read.
REQ-009 SHALL have ports issue_wr  input  1 and issue_rd  input  REG_AW  instruction writes rd.
REQ-010 SHALL have port issue_ld  input  1  instruction is a load (result available only at its last stage).
REQ-011 SHALL have port flush  input  1  taken branch; squash the decode-stage instruction.
REQ-012 SHALL have port stall  output  1  hold fetch/decode this cycle (combinational).
REQ-013 SHALL have port issue_fire  output  1  = issue_valid & ~stall & ~flush.
REQ-014 SHALL have ports fwd_a, fwd_b  output  clog2(DEPTH+1) each  source select: 0 register file, k = stage k-1.
REQ-015 SHALL have port inflight  output  clog2(DEPTH+1)  count of valid stage entries.
REQ-016 SHALL have port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-017 SHALL hold DEPTH entries {valid, ld, dst}; each cycle entry k <= entry k-1, entry DEPTH-1 retires.
REQ-018 SHALL load entry 0 with {1, issue_ld, issue_rd} when issue_fire & issue_wr & issue_rd!=0, else a bubble (valid=0).
REQ-019 SHALL treat register address 0 as never pending and never matching.
REQ-020 SHALL define a source match as: source used, address nonzero, equal to a valid entry's dst; youngest (lowest k) match wins.
REQ-021 SHALL assert stall only when issue_valid is high and a hazard per REQ-027/028 exists.
REQ-022 SHALL give flush priority over stall: flush high -> issue_fire=0, bubble inserted, stall_cnt not incremented.
REQ-023 SHALL keep shifting entries while stalled (bubble into entry 0) so the hazard drains.
REQ-024 SHALL increment stall_cnt by 1 each cycle stall=1 and flush=0, saturating at 2^CNT_W-1.
REQ-025 SHALL evaluate rs and rt independently; stall if either hazards; fwd outputs 0 while stall=1.
REQ-026 SHALL make inflight equal the popcount of valid bits, registered state only.

Configuration
REQ-027 SHALL, with macro PIPE_SB_FWD_EN defined, stall only when the youngest match for a source is entry 0 with ld=1 (load-use), and otherwise drive fwd_a/fwd_b = k+1 for the youngest matching entry k.
REQ-028 SHALL, without PIPE_SB_FWD_EN, stall on any match in any entry and tie fwd_a/fwd_b to 0.

Reset
REQ-029 SHALL on rst clear all valid bits, ld bits, dst fields and stall_cnt to 0 at the next rising edge.
REQ-030 SHALL after reset present stall=0 (absent inputs), issue_fire=issue_valid&~flush, fwd=0, inflight=0.
REQ-031 SHALL discard in-flight entries when rst asserts mid-operation; no entry survives the reset edge.
REQ-032 SHALL give rst priority over issue and flush in the same cycle.

Verification
REQ-033 SHALL cover: DEPTH=3, no macro; issue wr r5, then rs=r5 next cycle -> stall for 3 cycles, fire on 4th, stall_cnt=3.
REQ-034 SHALL cover: macro on; ALU wr r5 then rs=r5 -> no stall, fwd_a=1; one bubble later -> fwd_a=2.
REQ-035 SHALL cover: macro on; load r7 then rt=r7 -> stall exactly 1 cycle, then fwd_b=2.
REQ-036 SHALL cover: issue wr r0 then rs=r0 -> no stall, inflight stays 0.
REQ-037 SHALL cover: flush with hazard pending -> issue_fire=0, stall_cnt unchanged; rst with 3 valid entries -> inflight=0 next cycle.
REQ-038 SHALL cover: CNT_W=2, continuous hazard 5 cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_sb_if.sv
// pipe_sb_if: decode-to-scoreboard issue bundle (request fields in, stall/fire/forward selects out)
interface pipe_sb_if #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5
);
    localparam int FW = $clog2(DEPTH + 1);
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs;
    logic [REG_AW-1:0] issue_rt;
    logic              issue_rs_used;
    logic              issue_rt_used;
    logic              issue_wr;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_ld;
    logic              flush;
    logic              stall;
    logic              issue_fire;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_wr, issue_rd, issue_ld, flush,
        input  stall, issue_fire, fwd_a, fwd_b
    );
    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_wr, issue_rd, issue_ld, flush,
        output stall, issue_fire, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-order pipeline hazard scoreboard; define PIPE_SB_FWD_EN for forwarding (stall only on load-use)
module pipe_scoreboard #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pipe_sb_if.slave                     sb,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic [CNT_W-1:0]             stall_cnt
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d, ld_q, ld_d;
    logic [REG_AW-1:0] dst_q [DEPTH];
    logic [REG_AW-1:0] dst_d [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              hit_a, hit_b, ld_a, ld_b, haz_a, haz_b, push;
    logic [FW-1:0]     idx_a, idx_b;

    // youngest pending entry matching each used, nonzero source
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx_a = '0;
        idx_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb.issue_rs_used && sb.issue_rs != '0 && valid_q[k] && dst_q[k] == sb.issue_rs) begin
                hit_a = 1'b1;
                idx_a = FW'(k);
                ld_a  = ld_q[k];
            end
            if (sb.issue_rt_used && sb.issue_rt != '0 && valid_q[k] && dst_q[k] == sb.issue_rt) begin
                hit_b = 1'b1;
                idx_b = FW'(k);
                ld_b  = ld_q[k];
            end
        end
    end

`ifdef PIPE_SB_FWD_EN
    assign haz_a    = hit_a && idx_a == '0 && ld_a;
    assign haz_b    = hit_b && idx_b == '0 && ld_b;
    assign sb.fwd_a = (hit_a && !sb.stall) ? idx_a + FW'(1) : '0;
    assign sb.fwd_b = (hit_b && !sb.stall) ? idx_b + FW'(1) : '0;
`else
    logic unused_sel;
    assign unused_sel = ^{idx_a, idx_b, ld_a, ld_b};
    assign haz_a    = hit_a;
    assign haz_b    = hit_b;
    assign sb.fwd_a = '0;
    assign sb.fwd_b = '0;
`endif

    assign sb.stall      = sb.issue_valid && (haz_a || haz_b);
    assign sb.issue_fire = sb.issue_valid && !sb.stall && !sb.flush;
    assign push          = sb.issue_fire && sb.issue_wr && sb.issue_rd != '0;
    assign inflight      = FW'($countones(valid_q));
    assign stall_cnt     = stall_cnt_q;

    // shift entries every cycle, new issue or bubble into entry 0, saturating stall count
    always_comb begin
        valid_d[0] = push;
        ld_d[0]    = push && sb.issue_ld;
        dst_d[0]   = push ? sb.issue_rd : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            ld_d[k]    = ld_q[k-1];
            dst_d[k]   = dst_q[k-1];
        end
        stall_cnt_d = (sb.stall && !sb.flush && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // state registers; reset wipes every entry regardless of issue/flush
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            ld_q        <= '0;
            dst_q       <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ld_q        <= ld_d;
            dst_q       <= dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed and random checks of pipe_scoreboard against a behavioural model
module tb_pipe_scoreboard;
    localparam int DEPTH  = 3;
    localparam int REG_AW = 5;
    localparam int FW     = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_sb_if #(.DEPTH(DEPTH), .REG_AW(REG_AW)) sb ();
    pipe_sb_if #(.DEPTH(DEPTH), .REG_AW(REG_AW)) sb2 ();
    logic [FW-1:0] inflight, inflight2;
    logic [15:0]   cnt;
    logic [1:0]    cnt2;

    pipe_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .sb(sb), .inflight(inflight), .stall_cnt(cnt)
    );
    pipe_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .sb(sb2), .inflight(inflight2), .stall_cnt(cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural model: list of pending writes, youngest first
    bit m_valid [DEPTH];
    bit m_ld    [DEPTH];
    int m_dst   [DEPTH];
    int m_cnt = 0;
    bit chk_on = 1'b0;

    function automatic int youngest(input logic used, input int addr);
        if (!used || addr == 0) return -1;
        for (int k = 0; k < DEPTH; k++)
            if (m_valid[k] && m_dst[k] == addr) return k;
        return -1;
    endfunction

    function automatic bit blocks(input int k);
`ifdef PIPE_SB_FWD_EN
        return k == 0 && m_ld[0];
`else
        return k >= 0;
`endif
    endfunction

    function automatic int fwd_sel(input int k, input bit st);
`ifdef PIPE_SB_FWD_EN
        return (k >= 0 && !st) ? k + 1 : 0;
`else
        return (k >= 0 && !st) ? 0 : 0;
`endif
    endfunction

    task automatic model_out(output bit st, output bit fi, output int fa, output int fb);
        int ka, kb;
        ka = youngest(sb.issue_rs_used, int'(sb.issue_rs));
        kb = youngest(sb.issue_rt_used, int'(sb.issue_rt));
        st = sb.issue_valid && (blocks(ka) || blocks(kb));
        fi = sb.issue_valid && !st && !sb.flush;
        fa = fwd_sel(ka, st);
        fb = fwd_sel(kb, st);
    endtask

    function automatic int model_inflight();
        int n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(m_valid[k]);
        return n;
    endfunction

    // model state advance on each rising edge
    always @(posedge clk) begin
        bit st, fi;
        int fa, fb;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 1'b0;
                m_ld[k]    = 1'b0;
                m_dst[k]   = 0;
            end
            m_cnt  = 0;
            chk_on = 1'b1;
        end else begin
            model_out(st, fi, fa, fb);
            if (st && !sb.flush && m_cnt < 65535) m_cnt++;
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_ld[k]    = m_ld[k-1];
                m_dst[k]   = m_dst[k-1];
            end
            m_valid[0] = fi && sb.issue_wr && sb.issue_rd != '0;
            m_ld[0]    = sb.issue_ld;
            m_dst[0]   = int'(sb.issue_rd);
        end
    end

    // per-cycle comparison of both DUTs against the model, mid-cycle
    always @(negedge clk) begin
        bit st, fi;
        int fa, fb;
        if (chk_on) begin
            #2;
            model_out(st, fi, fa, fb);
            chk("stall", int'(sb.stall), int'(st));
            chk("issue_fire", int'(sb.issue_fire), int'(fi));
            chk("fwd_a", int'(sb.fwd_a), fa);
            chk("fwd_b", int'(sb.fwd_b), fb);
            chk("inflight", int'(inflight), model_inflight());
            chk("stall_cnt", int'(cnt), m_cnt);
            chk("sat_stall", int'(sb2.stall), int'(st));
            chk("sat_inflight", int'(inflight2), model_inflight());
            chk("sat_stall_cnt", int'(cnt2), m_cnt > 3 ? 3 : m_cnt);
        end
    end

    // one cycle: drive both interfaces at the falling edge, settle before literal checks
    task automatic cyc(input logic r, input logic v, input int rs, input logic rsu, input int rt,
                       input logic rtu, input logic wr, input int rd, input logic ld, input logic fl);
        @(negedge clk);
        rst = r;
        sb.issue_valid   = v;   sb2.issue_valid   = v;
        sb.issue_rs      = REG_AW'(rs); sb2.issue_rs = REG_AW'(rs);
        sb.issue_rs_used = rsu; sb2.issue_rs_used = rsu;
        sb.issue_rt      = REG_AW'(rt); sb2.issue_rt = REG_AW'(rt);
        sb.issue_rt_used = rtu; sb2.issue_rt_used = rtu;
        sb.issue_wr      = wr;  sb2.issue_wr      = wr;
        sb.issue_rd      = REG_AW'(rd); sb2.issue_rd = REG_AW'(rd);
        sb.issue_ld      = ld;  sb2.issue_ld      = ld;
        sb.flush         = fl;  sb2.flush         = fl;
        #3;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", int'(sb.stall), 0);
        chk("rst_fire", int'(sb.issue_fire), 1);
        chk("rst_fwd_a", int'(sb.fwd_a), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_cnt", int'(cnt), 0);
`ifdef PIPE_SB_FWD_EN
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        chk("alu_fire", int'(sb.issue_fire), 1);
        cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_use_stall", int'(sb.stall), 0);
        chk("alu_use_fwd1", int'(sb.fwd_a), 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_bubble_fwd2", int'(sb.fwd_a), 2);
        cyc(0, 1, 0, 0, 0, 0, 1, 7, 1, 0);
        cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("load_use_stall", int'(sb.stall), 1);
        cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("load_use_release", int'(sb.stall), 0);
        chk("load_use_fwd_b", int'(sb.fwd_b), 2);
        cyc(0, 1, 0, 0, 0, 0, 1, 9, 1, 0);
        cyc(0, 1, 9, 1, 0, 0, 0, 0, 0, 1);
        chk("flush_fire", int'(sb.issue_fire), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_cnt", int'(cnt), 1);
`else
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        chk("wr_r5_fire", int'(sb.issue_fire), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
            chk("raw_stall", int'(sb.stall), 1);
        end
        cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("raw_release", int'(sb.stall), 0);
        chk("raw_fire", int'(sb.issue_fire), 1);
        chk("raw_cnt", int'(cnt), 3);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", int'(sb.stall), 0);
        chk("r0_inflight", int'(inflight), 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 9, 0, 0);
        cyc(0, 1, 9, 1, 0, 0, 0, 0, 0, 1);
        chk("flush_fire", int'(sb.issue_fire), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_cnt", int'(cnt), 3);
`endif
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
        chk("pre_rst_inflight", int'(inflight), 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_inflight", int'(inflight), 0);
        chk("post_rst_cnt", int'(cnt), 0);
`ifndef PIPE_SB_FWD_EN
        cyc(0, 1, 0, 0, 0, 0, 1, 6, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 6, 1, 0, 0, 1, 6, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_wide_cnt", int'(cnt), 6);
        chk("sat_narrow_cnt", int'(cnt2), 3);
`endif
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
